// File: rtl/reg_arb_pkg.sv
// ----------------------------------------------------------------------------
// reg_arb_pkg
// Shared types and constants for the LC-3 register-file arbiter.
//   DEF_DATA_W / DEF_ADDR_W : default register width / register index width
//   STARVE_W                : width of the debug starvation counter (limit 1..15)
//   PERF_W                  : width of the optional performance counters
//   arb_state_t             : arbiter FSM states
//   req_t                   : one requester's access request bundle
//   sat_inc                 : saturating increment for the performance counters
// ----------------------------------------------------------------------------
package reg_arb_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 3;
  localparam int STARVE_W   = 4;
  localparam int PERF_W     = 16;

  typedef enum logic [1:0] {
    CPU_PRI   = 2'd0,
    DBG_FORCE = 2'd1,
    LOCKED    = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic                  req;
    logic                  we;
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] wdata;
  } req_t;

  // Counters stick at all-ones instead of wrapping back to zero.
  function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] value);
    return (value == '1) ? value : value + PERF_W'(1);
  endfunction

endpackage

// File: rtl/reg_file_arbiter_if.sv
// ----------------------------------------------------------------------------
// reg_file_arbiter_if
// Requester-side bus of the register-file arbiter: the CPU and debug access
// handshakes plus the debug lock control and lock status.
//   master : driven by the requesters (CPU datapath / debug host)
//   slave  : seen by the arbiter
// ----------------------------------------------------------------------------
interface reg_file_arbiter_if
  import reg_arb_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
);

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_gnt;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_rvalid;

  logic              dbg_req;
  logic              dbg_we;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_wdata;
  logic              dbg_gnt;
  logic [DATA_W-1:0] dbg_rdata;
  logic              dbg_rvalid;
  logic              dbg_lock;

  logic              locked;

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_lock,
    input  cpu_gnt, cpu_rdata, cpu_rvalid,
    input  dbg_gnt, dbg_rdata, dbg_rvalid,
    input  locked
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_lock,
    output cpu_gnt, cpu_rdata, cpu_rvalid,
    output dbg_gnt, dbg_rdata, dbg_rvalid,
    output locked
  );

endinterface

// File: rtl/arb_starve_cnt.sv
// ----------------------------------------------------------------------------
// arb_starve_cnt
// Saturating count of consecutive cycles in which debug asked for the port
// and was refused.
//   clk, rst  : clock, asynchronous active-high reset
//   starve    : debug requesting and not granted this cycle
//   limit_hit : the count is at LIMIT after this edge (debug must win next)
// ----------------------------------------------------------------------------
module arb_starve_cnt
  import reg_arb_pkg::*;
#(
  parameter int LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic starve,
  output logic limit_hit
);

  localparam logic [STARVE_W-1:0] LIMIT_V = STARVE_W'(LIMIT);

  logic [STARVE_W-1:0] count;
  logic [STARVE_W-1:0] count_next;

  // Any cycle without starvation (debug granted or not asking) restarts the
  // run; otherwise count up and stick at the limit.
  always_comb begin
    count_next = '0;
    if (starve) begin
      count_next = (count == LIMIT_V) ? count : count + STARVE_W'(1);
    end
  end

  // Flag is derived from the next value so the FSM can switch to forced
  // debug priority on the same edge the limit is reached.
  assign limit_hit = starve && (count_next == LIMIT_V);

  // Holds the starvation run length.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else begin
      count <= count_next;
    end
  end

endmodule

// File: rtl/reg_file_arbiter.sv
// ----------------------------------------------------------------------------
// reg_file_arbiter
// Shares the LC-3 register file's write port and SR1 read port between the
// CPU datapath (default priority) and the debug/host port. One access per
// cycle; debug is forced through after STARVE_LIMIT refused cycles and can
// lock the port for atomic multi-access sequences.
//
// Ports:
//   Clk, Reset_ah : clock, asynchronous active-high reset
//   bus           : requester handshakes (reg_file_arbiter_if.slave)
//   rf_ld_reg     : reg_file LD_REG
//   rf_dr         : reg_file DRMUX_out (write index)
//   rf_sr1        : reg_file SR1MUX_out (read index)
//   rf_wdata      : reg_file bus_data (write data)
//   rf_sr1_data   : reg_file SR1_OUT (read data)
//
// Optional feature, macro REG_ARB_PERF_EN:
//   cpu_gnt_cnt, dbg_gnt_cnt : granted transfers per requester
//   cpu_stall_cnt            : cycles with the CPU requesting but refused
//   All saturate at 0xFFFF. Without the macro these ports do not exist.
//
// Parameters: DATA_W, ADDR_W, STARVE_LIMIT (1..15).
// ----------------------------------------------------------------------------
module reg_file_arbiter
  import reg_arb_pkg::*;
#(
  parameter int DATA_W       = DEF_DATA_W,
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              Clk,
  input  logic              Reset_ah,
  reg_file_arbiter_if.slave bus,
  output logic              rf_ld_reg,
  output logic [ADDR_W-1:0] rf_dr,
  output logic [ADDR_W-1:0] rf_sr1,
  output logic [DATA_W-1:0] rf_wdata,
  input  logic [DATA_W-1:0] rf_sr1_data
`ifdef REG_ARB_PERF_EN
  ,
  output logic [PERF_W-1:0] cpu_gnt_cnt,
  output logic [PERF_W-1:0] dbg_gnt_cnt,
  output logic [PERF_W-1:0] cpu_stall_cnt
`endif
);

  arb_state_t        state;
  logic              locked_q;
  logic              cpu_gnt_c;
  logic              dbg_gnt_c;
  logic              dbg_starve;
  logic              starve_hit;
  logic              cpu_rvalid_q;
  logic              dbg_rvalid_q;
  logic [DATA_W-1:0] cpu_rdata_q;
  logic [DATA_W-1:0] dbg_rdata_q;

  // Same-cycle grant decision. Grants are held low while reset is asserted
  // so every output reads zero during reset. In DBG_FORCE the CPU may still
  // use an otherwise idle port while debug is not asking.
  always_comb begin
    cpu_gnt_c = 1'b0;
    dbg_gnt_c = 1'b0;
    if (!Reset_ah) begin
      case (state)
        CPU_PRI: begin
          cpu_gnt_c = bus.cpu_req;
          dbg_gnt_c = bus.dbg_req && !bus.cpu_req;
        end
        DBG_FORCE: begin
          dbg_gnt_c = bus.dbg_req;
          cpu_gnt_c = bus.cpu_req && !bus.dbg_req;
        end
        LOCKED: begin
          dbg_gnt_c = bus.dbg_req;
        end
        default: begin
          cpu_gnt_c = 1'b0;
          dbg_gnt_c = 1'b0;
        end
      endcase
    end
  end

  // Steer the winner onto the register-file ports; everything idles at 0.
  always_comb begin
    rf_ld_reg = 1'b0;
    rf_dr     = '0;
    rf_sr1    = '0;
    rf_wdata  = '0;
    if (cpu_gnt_c) begin
      if (bus.cpu_we) begin
        rf_ld_reg = 1'b1;
        rf_dr     = bus.cpu_addr;
        rf_wdata  = bus.cpu_wdata;
      end else begin
        rf_sr1 = bus.cpu_addr;
      end
    end else if (dbg_gnt_c) begin
      if (bus.dbg_we) begin
        rf_ld_reg = 1'b1;
        rf_dr     = bus.dbg_addr;
        rf_wdata  = bus.dbg_wdata;
      end else begin
        rf_sr1 = bus.dbg_addr;
      end
    end
  end

  assign dbg_starve = bus.dbg_req && !dbg_gnt_c;

  arb_starve_cnt #(
    .LIMIT(STARVE_LIMIT)
  ) u_starve (
    .clk      (Clk),
    .rst      (Reset_ah),
    .starve   (dbg_starve),
    .limit_hit(starve_hit)
  );

  // Arbitration FSM with the registered lock status. A granted debug transfer
  // carrying dbg_lock always ends in LOCKED; one without it always ends in
  // CPU_PRI. Starvation only matters while the CPU has priority.
  always_ff @(posedge Clk or posedge Reset_ah) begin
    if (Reset_ah) begin
      state    <= CPU_PRI;
      locked_q <= 1'b0;
    end else begin
      case (state)
        CPU_PRI: begin
          if (dbg_gnt_c && bus.dbg_lock) begin
            state    <= LOCKED;
            locked_q <= 1'b1;
          end else if (starve_hit) begin
            state <= DBG_FORCE;
          end
        end
        DBG_FORCE: begin
          if (dbg_gnt_c) begin
            if (bus.dbg_lock) begin
              state    <= LOCKED;
              locked_q <= 1'b1;
            end else begin
              state    <= CPU_PRI;
              locked_q <= 1'b0;
            end
          end
        end
        LOCKED: begin
          if (dbg_gnt_c && !bus.dbg_lock) begin
            state    <= CPU_PRI;
            locked_q <= 1'b0;
          end
        end
        default: begin
          state    <= CPU_PRI;
          locked_q <= 1'b0;
        end
      endcase
    end
  end

  // Capture SR1_OUT at the edge closing a granted read and strobe rvalid for
  // one cycle; rdata then holds until that requester reads again.
  always_ff @(posedge Clk or posedge Reset_ah) begin
    if (Reset_ah) begin
      cpu_rvalid_q <= 1'b0;
      dbg_rvalid_q <= 1'b0;
      cpu_rdata_q  <= '0;
      dbg_rdata_q  <= '0;
    end else begin
      cpu_rvalid_q <= cpu_gnt_c && !bus.cpu_we;
      dbg_rvalid_q <= dbg_gnt_c && !bus.dbg_we;
      if (cpu_gnt_c && !bus.cpu_we) begin
        cpu_rdata_q <= rf_sr1_data;
      end
      if (dbg_gnt_c && !bus.dbg_we) begin
        dbg_rdata_q <= rf_sr1_data;
      end
    end
  end

  assign bus.cpu_gnt    = cpu_gnt_c;
  assign bus.dbg_gnt    = dbg_gnt_c;
  assign bus.cpu_rdata  = cpu_rdata_q;
  assign bus.dbg_rdata  = dbg_rdata_q;
  assign bus.cpu_rvalid = cpu_rvalid_q;
  assign bus.dbg_rvalid = dbg_rvalid_q;
  assign bus.locked     = locked_q;

`ifdef REG_ARB_PERF_EN
  // Usage statistics: transfers per requester and CPU cycles lost to debug.
  always_ff @(posedge Clk or posedge Reset_ah) begin
    if (Reset_ah) begin
      cpu_gnt_cnt   <= '0;
      dbg_gnt_cnt   <= '0;
      cpu_stall_cnt <= '0;
    end else begin
      if (cpu_gnt_c) begin
        cpu_gnt_cnt <= sat_inc(cpu_gnt_cnt);
      end
      if (dbg_gnt_c) begin
        dbg_gnt_cnt <= sat_inc(dbg_gnt_cnt);
      end
      if (bus.cpu_req && !cpu_gnt_c) begin
        cpu_stall_cnt <= sat_inc(cpu_stall_cnt);
      end
    end
  end
`endif

endmodule
